// File: rtl/avalon_slave_bridge.sv
// ============================================================================
// Module   : avalon_slave_bridge
// Purpose  : Avalon-MM slave to local register-bus bridge with wait states.
//            Optional access timeout and sticky err flag: AVS_BRIDGE_TIMEOUT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module avalon_slave_bridge #(
    parameter int          AW      = 9,
    parameter int          DW      = 32,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            avs_chipselect_n,
    input  logic            avs_write_n,
    input  logic            avs_read_n,
    input  logic [AW-1:0]   avs_address,
    input  logic [DW-1:0]   avs_writedata,
    input  logic [DW/8-1:0] avs_byteenable,
    output logic [DW-1:0]   avs_readdata,
    output logic            avs_waitrequest,
    output logic            wr_n,
    output logic            rd_n,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] be,
    input  logic [DW-1:0]   rdata,
    input  logic            ack
`ifdef AVS_BRIDGE_TIMEOUT_EN
    ,
    output logic            err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    logic              is_wr_q;
    logic              wr_n_q;
    logic              rd_n_q;
    logic              wait_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   be_q;
    logic [DW-1:0]     rdata_q;

    logic              w_req;
    assign w_req = !avs_chipselect_n && (!avs_write_n || !avs_read_n);

`ifdef AVS_BRIDGE_TIMEOUT_EN
    localparam int          CW        = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] TO_DATA_W = DW'(TO_DATA);

    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          w_timeout;
    assign w_timeout = (cnt_q == CW'(TIMEOUT - 1));
    assign err       = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TO_DATA, TIMEOUT};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wait_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
`ifdef AVS_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: only the IDLE capture can pull them low.
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (w_req) begin
                        addr_q  <= avs_address;
                        wdata_q <= avs_writedata;
                        be_q    <= avs_byteenable;
                        is_wr_q <= !avs_write_n;
                        wr_n_q  <= avs_write_n;
                        rd_n_q  <= !avs_write_n;
`ifdef AVS_BRIDGE_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ack) begin
                        if (!is_wr_q) begin
                            rdata_q <= rdata;
                        end
                        wait_q  <= 1'b0;
                        state_q <= DONE;
                    end
`ifdef AVS_BRIDGE_TIMEOUT_EN
                    else if (w_timeout) begin
                        if (!is_wr_q) begin
                            rdata_q <= TO_DATA_W;
                        end
                        err_q   <= 1'b1;
                        wait_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                DONE: begin
                    wait_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    wait_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = wait_q;
    assign wr_n            = wr_n_q;
    assign rd_n            = rd_n_q;
    assign addr            = addr_q;
    assign wdata           = wdata_q;
    assign be              = be_q;

endmodule

`default_nettype wire

// File: tb/tb_avalon_slave_bridge.sv
// ============================================================================
// Module   : tb_avalon_slave_bridge
// Purpose  : Scoreboard bench for avalon_slave_bridge (TIMEOUT=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avalon_slave_bridge;

    logic        clk;
    logic        rst_n;
    logic        avs_chipselect_n;
    logic        avs_write_n;
    logic        avs_read_n;
    logic [8:0]  avs_address;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        wr_n;
    logic        rd_n;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
`ifdef AVS_BRIDGE_TIMEOUT_EN
    logic        err;
`endif

    avalon_slave_bridge #(
        .AW(9), .DW(32), .TIMEOUT(4), .TO_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .avs_chipselect_n(avs_chipselect_n), .avs_write_n(avs_write_n),
        .avs_read_n(avs_read_n), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .wr_n(wr_n), .rd_n(rd_n), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata), .ack(ack)
`ifdef AVS_BRIDGE_TIMEOUT_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] model_rd = '0;

    // Strobe record: {write, read, addr, wdata, be}
    logic [46:0] exp_s[$];
    logic [46:0] obs_s[$];
    int          obs_sc[$];
    logic [31:0] exp_d[$];
    logic [31:0] obs_d[$];
    int          obs_dc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!wr_n || !rd_n) begin
                obs_s.push_back({!wr_n, !rd_n, addr, wdata, be});
                obs_sc.push_back(cyc);
            end
            if (!avs_waitrequest) begin
                obs_d.push_back(avs_readdata);
                obs_dc.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        exp_s.delete(); obs_s.delete(); obs_sc.delete();
        exp_d.delete(); obs_d.delete(); obs_dc.delete();
    endtask

    // Master + local responder: called at a negedge, returns at the DONE negedge.
    task automatic xfer(input bit w, input bit r, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input int dly, input bit give_ack, input logic [31:0] rv);
        int j;
        bit done;
        j = -1;
        done = 1'b0;
        avs_chipselect_n = 1'b0; avs_write_n = !w; avs_read_n = !r;
        avs_address = a; avs_writedata = d; avs_byteenable = b;
        exp_s.push_back({w, !w, a, d, b});
        if (!w) model_rd = give_ack ? rv : 32'hDEAD_BEEF;
        exp_d.push_back(model_rd);
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                done = 1'b1;
                ack  = 1'b0;
            end else begin
                if (j >= 0) j++;
                else if (!wr_n || !rd_n) j = 0;
                ack   = give_ack && (j == dly);
                rdata = ack ? rv : 32'h0BAD_0BAD;
            end
        end
        avs_chipselect_n = 1'b1; avs_write_n = 1'b1; avs_read_n = 1'b1; ack = 1'b0;
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL xfer_complete: waitrequest never low, addr=%h", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        avs_chipselect_n = 1'b1; avs_write_n = 1'b1; avs_read_n = 1'b1;
        avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
        rdata = '0; ack = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (wr_n !== 1'b1) begin n_fail++; $display("FAIL rst_wr_n got=%b exp=1", wr_n); end
        n_chk++; if (rd_n !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n got=%b exp=1", rd_n); end
        n_chk++; if (addr !== 9'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", addr); end
        n_chk++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
        n_chk++; if (be !== 4'h0) begin n_fail++; $display("FAIL rst_be got=%h exp=0", be); end
        n_chk++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata got=%h exp=0", avs_readdata); end
        n_chk++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_waitreq got=%b exp=1", avs_waitrequest); end
`ifdef AVS_BRIDGE_TIMEOUT_EN
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
`endif
        rst_n = 1'b1;
        clear_q();
        // Stray ack while idle must not start anything.
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        n_chk++; if (obs_s.size() != 0 || obs_d.size() != 0) begin
            n_fail++; $display("FAIL idle_ack strobes=%0d done=%0d exp=0,0", obs_s.size(), obs_d.size());
        end
    endtask

    task automatic test_write();
        logic [46:0] es;
        clear_q();
        xfer(1'b1, 1'b0, 9'h1A5, 32'h1234_5678, 4'hF, 0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        es = exp_s.pop_front();
        n_chk++;
        if (obs_s.size() != 1) begin
            n_fail++; $display("FAIL write_strobe_count got=%0d exp=1", obs_s.size());
        end else begin
            n_chk++; if (obs_s[0] !== es) begin n_fail++; $display("FAIL write_strobe got=%h exp=%h", obs_s[0], es); end
            n_chk++; if (obs_dc.size() != 1 || obs_dc[0] - obs_sc[0] != 1) begin
                n_fail++; $display("FAIL write_wait_low lowcycles=%0d exp=1 (one cycle after strobe)", obs_dc.size());
            end
        end
        n_chk++; if (avs_readdata !== exp_d.pop_front()) begin n_fail++; $display("FAIL write_readdata got=%h exp=0", avs_readdata); end
    endtask

    task automatic test_read();
        logic [46:0] es;
        logic [31:0] ed;
        clear_q();
        xfer(1'b0, 1'b1, 9'h003, 32'h0, 4'hF, 4, 1'b1, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        es = exp_s.pop_front();
        ed = exp_d.pop_front();
        n_chk++;
        if (obs_s.size() != 1 || obs_d.size() != 1) begin
            n_fail++; $display("FAIL read_counts strobes=%0d done=%0d exp=1,1", obs_s.size(), obs_d.size());
        end else begin
            n_chk++; if (obs_s[0] !== es) begin n_fail++; $display("FAIL read_strobe got=%h exp=%h", obs_s[0], es); end
            n_chk++; if (obs_d[0] !== ed) begin n_fail++; $display("FAIL read_data got=%h exp=%h", obs_d[0], ed); end
            n_chk++; if (obs_dc[0] - obs_sc[0] != 5) begin n_fail++; $display("FAIL read_latency got=%0d exp=5", obs_dc[0] - obs_sc[0]); end
        end
        n_chk++; if (avs_readdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_hold got=%h exp=cafef00d", avs_readdata); end
    endtask

    task automatic test_simultaneous();
        logic [46:0] es;
        logic [31:0] ed;
        clear_q();
        xfer(1'b1, 1'b1, 9'h055, 32'hA5A5_5A5A, 4'h3, 1, 1'b1, 32'h1111_1111);
        repeat (2) @(negedge clk);
        es = exp_s.pop_front();
        ed = exp_d.pop_front();
        n_chk++;
        if (obs_s.size() != 1) begin
            n_fail++; $display("FAIL simul_strobe_count got=%0d exp=1", obs_s.size());
        end else begin
            n_chk++; if (obs_s[0] !== es) begin n_fail++; $display("FAIL simul_strobe got=%h exp=%h", obs_s[0], es); end
        end
        n_chk++; if (avs_readdata !== ed) begin n_fail++; $display("FAIL simul_readdata got=%h exp=%h", avs_readdata, ed); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        xfer(1'b1, 1'b0, 9'h101, 32'h0000_0001, 4'h1, 0, 1'b1, 32'h0);
        xfer(1'b0, 1'b1, 9'h102, 32'h0000_0002, 4'h2, 0, 1'b1, 32'h5555_AAAA);
        xfer(1'b1, 1'b0, 9'h103, 32'h0000_0003, 4'h4, 0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs_s.size() != 3 || obs_d.size() != 3) begin
            n_fail++; $display("FAIL b2b_counts strobes=%0d done=%0d exp=3,3", obs_s.size(), obs_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (obs_s[i] !== exp_s[i]) begin n_fail++; $display("FAIL b2b_strobe%0d got=%h exp=%h", i, obs_s[i], exp_s[i]); end
                n_chk++; if (obs_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data%0d got=%h exp=%h", i, obs_d[i], exp_d[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                n_chk++; if (obs_sc[i+1] - obs_sc[i] != 3) begin
                    n_fail++; $display("FAIL b2b_spacing%0d got=%0d exp=3", i, obs_sc[i+1] - obs_sc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [46:0] es;
        avs_chipselect_n = 1'b0; avs_write_n = 1'b1; avs_read_n = 1'b0;
        avs_address = 9'h0AA; avs_writedata = 32'h0; avs_byteenable = 4'hF;
        @(negedge clk);
        n_chk++; if (rd_n !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe got=%b exp=0", rd_n); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (rd_n !== 1'b1) begin n_fail++; $display("FAIL midrst_rd_n got=%b exp=1", rd_n); end
        n_chk++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL midrst_waitreq got=%b exp=1", avs_waitrequest); end
        n_chk++; if (addr !== 9'h0) begin n_fail++; $display("FAIL midrst_addr got=%h exp=0", addr); end
        n_chk++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_readdata got=%h exp=0", avs_readdata); end
        avs_chipselect_n = 1'b1; avs_read_n = 1'b1;
        model_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        xfer(1'b1, 1'b0, 9'h0F0, 32'hFEED_FACE, 4'hC, 2, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        es = exp_s.pop_front();
        n_chk++;
        if (obs_s.size() != 1 || obs_d.size() != 1) begin
            n_fail++; $display("FAIL postrst_counts strobes=%0d done=%0d exp=1,1", obs_s.size(), obs_d.size());
        end else begin
            n_chk++; if (obs_s[0] !== es) begin n_fail++; $display("FAIL postrst_strobe got=%h exp=%h", obs_s[0], es); end
        end
    endtask

`ifdef AVS_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        clear_q();
        xfer(1'b0, 1'b1, 9'h010, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_s.size() != 1 || obs_d.size() != 1) begin
            n_fail++; $display("FAIL to_counts strobes=%0d done=%0d exp=1,1", obs_s.size(), obs_d.size());
        end else begin
            n_chk++; if (obs_dc[0] - obs_sc[0] != 4) begin n_fail++; $display("FAIL to_latency got=%0d exp=4", obs_dc[0] - obs_sc[0]); end
            n_chk++; if (obs_d[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_data got=%h exp=deadbeef", obs_d[0]); end
        end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_rd = '0;
        @(negedge clk);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared got=%b exp=0", err); end
        clear_q();
        xfer(1'b0, 1'b1, 9'h011, 32'h0, 4'hF, 3, 1'b1, 32'h600D_F00D);
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs_d.size() != 1 || obs_s.size() != 1) begin
            n_fail++; $display("FAIL to_ack_counts strobes=%0d done=%0d exp=1,1", obs_s.size(), obs_d.size());
        end else begin
            n_chk++; if (obs_d[0] !== 32'h600D_F00D) begin n_fail++; $display("FAIL to_ack_data got=%h exp=600df00d", obs_d[0]); end
            n_chk++; if (obs_dc[0] - obs_sc[0] != 4) begin n_fail++; $display("FAIL to_ack_latency got=%0d exp=4", obs_dc[0] - obs_sc[0]); end
        end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_ack_err got=%b exp=0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
`ifdef AVS_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
